pipelining_mips32: RTL and testbench

Five-stage in-order MIPS32-subset pipeline (IF, ID, EX, MEM, WB) with a unified 1024×32 word-addressed instruction/data memory and a 32×32 register file, both internal. It is the processor core of the pipelining demo design. It runs a preloaded program from PC 0 until a HLT instruction retires. There is no forwarding and no interlock: software schedules around hazards.

---
 rtl/pipelining_mips32_pkg.sv | 52 +++++
 rtl/pipelining_mips32_if.sv | 11 +
 rtl/pipelining_mips32_alu.sv | 27 ++
 rtl/pipelining_mips32.sv | 131 +++++++++++++
 tb/tb_pipelining_mips32.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelining_mips32_pkg.sv
// Shared opcodes, instruction classes and field slices for the pipelining_mips32 core.
// PIPE_MUL_EN: when defined, MUL decodes as a register ALU op; otherwise it is a bubble.
package pipelining_mips32_pkg;

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_AND   = 6'b000010;
   localparam logic [5:0] OP_OR    = 6'b000011;
   localparam logic [5:0] OP_SLT   = 6'b000100;
   localparam logic [5:0] OP_MUL   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b001000;
   localparam logic [5:0] OP_SW    = 6'b001001;
   localparam logic [5:0] OP_ADDI  = 6'b001010;
   localparam logic [5:0] OP_SUBI  = 6'b001011;
   localparam logic [5:0] OP_SLTI  = 6'b001100;
   localparam logic [5:0] OP_BNEQZ = 6'b001101;
   localparam logic [5:0] OP_BEQZ  = 6'b001110;
   localparam logic [5:0] OP_HLT   = 6'b111111;

   localparam int OP_HI  = 31;
   localparam int OP_LO  = 26;
   localparam int RS_HI  = 25;
   localparam int RS_LO  = 21;
   localparam int RT_HI  = 20;
   localparam int RT_LO  = 16;
   localparam int RD_HI  = 15;
   localparam int RD_LO  = 11;
   localparam int IMM_HI = 15;
   localparam int IMM_LO = 0;

   typedef enum logic [2:0] {
      RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, BUBBLE
   } itype_t;

   function automatic itype_t decode(input logic [5:0] op);
      itype_t t;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT:   t = RR_ALU;
`ifdef PIPE_MUL_EN
         OP_MUL:                                  t = RR_ALU;
`endif
         OP_ADDI, OP_SUBI, OP_SLTI:               t = RM_ALU;
         OP_LW:                                   t = LOAD;
         OP_SW:                                   t = STORE;
         OP_BNEQZ, OP_BEQZ:                       t = BRANCH;
         OP_HLT:                                  t = HALT;
         default:                                 t = BUBBLE;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/pipelining_mips32_if.sv
// Observation bus of the core: fetch PC, halt flag and the register write happening in WB.
interface pipelining_mips32_if;
   logic [31:0] pc;
   logic        halted;
   logic        wb_we;
   logic [4:0]  wb_dst;
   logic [31:0] wb_data;

   modport master (output pc, halted, wb_we, wb_dst, wb_data);
   modport slave  (input  pc, halted, wb_we, wb_dst, wb_data);
endinterface

// File: rtl/pipelining_mips32_alu.sv
// Combinational EX-stage ALU; loads/stores reuse the adder for address generation.
// PIPE_MUL_EN: when defined, a 32x32 low-word multiplier is built for MUL.
module pipelining_mips32_alu
   import pipelining_mips32_pkg::*;
(
   input  logic [5:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);

   always_comb begin
      y = '0;
      case (op)
         OP_ADD, OP_ADDI, OP_LW, OP_SW: y = a + b;
         OP_SUB, OP_SUBI:               y = a - b;
         OP_AND:                        y = a & b;
         OP_OR:                         y = a | b;
         OP_SLT, OP_SLTI:               y = {31'b0, $signed(a) < $signed(b)};
`ifdef PIPE_MUL_EN
         OP_MUL:                        y = a * b;
`endif
         default:                       y = '0;
      endcase
   end

endmodule

// File: rtl/pipelining_mips32.sv
// Five-stage MIPS32-subset core, no forwarding or interlocks; runs from PC 0 until HLT retires.
// PIPE_MUL_EN: enables the MUL instruction (otherwise MUL is a bubble).
module pipelining_mips32
   import pipelining_mips32_pkg::*;
(
   input  logic clk1,
   input  logic rst_n,
   pipelining_mips32_if.master st
);

   logic [31:0] Register [0:31];
   logic [31:0] Memory   [0:1023];
   logic [31:0] PC;
   logic        HALTED;

   logic [31:0] if_id_ir, if_id_npc;

   itype_t      id_ex_type;
   logic [5:0]  id_ex_op;
   logic [4:0]  id_ex_dst;
   logic [31:0] id_ex_npc, id_ex_a, id_ex_b, id_ex_imm;

   itype_t      ex_mem_type;
   logic [4:0]  ex_mem_dst;
   logic [31:0] ex_mem_alu, ex_mem_b;

   itype_t      mem_wb_type;
   logic [4:0]  mem_wb_dst;
   logic [31:0] mem_wb_res;

   // ID decode
   logic [5:0]  id_op;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [31:0] id_imm, id_a, id_b;
   itype_t      id_type;

   assign id_op   = if_id_ir[OP_HI:OP_LO];
   assign id_rs   = if_id_ir[RS_HI:RS_LO];
   assign id_rt   = if_id_ir[RT_HI:RT_LO];
   assign id_rd   = if_id_ir[RD_HI:RD_LO];
   assign id_imm  = {{16{if_id_ir[IMM_HI]}}, if_id_ir[IMM_HI:IMM_LO]};
   assign id_type = decode(id_op);

   logic wb_we, halting;
   assign wb_we   = !HALTED && (mem_wb_type inside {RR_ALU, RM_ALU, LOAD}) && (mem_wb_dst != 5'd0);
   assign halting = HALTED || (mem_wb_type == HALT);

   // Write-through: a WB write in this cycle is visible to the ID read.
   always_comb begin
      id_a = Register[id_rs];
      id_b = Register[id_rt];
      if (wb_we && mem_wb_dst == id_rs) id_a = mem_wb_res;
      if (wb_we && mem_wb_dst == id_rt) id_b = mem_wb_res;
      if (id_rs == 5'd0) id_a = '0;
      if (id_rt == 5'd0) id_b = '0;
   end

   // EX
   logic [31:0] alu_b, alu_y, br_target;
   logic        taken;

   assign alu_b     = (id_ex_type == RR_ALU) ? id_ex_b : id_ex_imm;
   assign br_target = id_ex_npc + id_ex_imm;
   assign taken     = (id_ex_type == BRANCH) && ((id_ex_op == OP_BEQZ) == (id_ex_a == 32'd0));

   pipelining_mips32_alu u_alu (
      .op (id_ex_op),
      .a  (id_ex_a),
      .b  (alu_b),
      .y  (alu_y)
   );

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         PC          <= '0;
         HALTED      <= 1'b0;
         if_id_ir    <= '0;
         if_id_npc   <= '0;
         id_ex_type  <= BUBBLE;
         id_ex_op    <= '0;
         id_ex_dst   <= '0;
         id_ex_npc   <= '0;
         id_ex_a     <= '0;
         id_ex_b     <= '0;
         id_ex_imm   <= '0;
         ex_mem_type <= BUBBLE;
         ex_mem_dst  <= '0;
         ex_mem_alu  <= '0;
         ex_mem_b    <= '0;
         mem_wb_type <= BUBBLE;
         mem_wb_dst  <= '0;
         mem_wb_res  <= '0;
      end else if (!halting) begin
         PC          <= taken ? br_target : PC + 32'd1;
         // A taken branch turns the two younger instructions into bubbles.
         if_id_ir    <= taken ? 32'd0 : Memory[PC[9:0]];
         if_id_npc   <= PC + 32'd1;
         id_ex_type  <= taken ? BUBBLE : id_type;
         id_ex_op    <= id_op;
         id_ex_dst   <= (id_type == RR_ALU) ? id_rd : id_rt;
         id_ex_npc   <= if_id_npc;
         id_ex_a     <= id_a;
         id_ex_b     <= id_b;
         id_ex_imm   <= id_imm;
         ex_mem_type <= id_ex_type;
         ex_mem_dst  <= id_ex_dst;
         ex_mem_alu  <= alu_y;
         ex_mem_b    <= id_ex_b;
         mem_wb_type <= ex_mem_type;
         mem_wb_dst  <= ex_mem_dst;
         mem_wb_res  <= (ex_mem_type == LOAD) ? Memory[ex_mem_alu[9:0]] : ex_mem_alu;
      end else begin
         HALTED      <= 1'b1;
      end
   end

   // Architectural storage survives reset; only the pipeline is cleared.
   always_ff @(posedge clk1) begin
      if (wb_we)
         Register[mem_wb_dst] <= mem_wb_res;
      if (!halting && ex_mem_type == STORE)
         Memory[ex_mem_alu[9:0]] <= ex_mem_b;
   end

   assign st.pc      = PC;
   assign st.halted  = HALTED;
   assign st.wb_we   = wb_we;
   assign st.wb_dst  = mem_wb_dst;
   assign st.wb_data = mem_wb_res;

endmodule

// File: tb/tb_pipelining_mips32.sv
// Directed bench for pipelining_mips32: register writes are scoreboarded against a queue
// of expected (dst, data) pairs; final state is read through the fixed hierarchical names.
module tb_pipelining_mips32;
   import pipelining_mips32_pkg::*;

   logic clk1;
   logic rst_n;
   int   ntests = 0;
   int   nfail  = 0;
   int   cyc;

   logic [36:0] exp_q [$];
   logic [31:0] prog  [$];

   pipelining_mips32_if st ();

   pipelining_mips32 dut (
      .clk1  (clk1),
      .rst_n (rst_n),
      .st    (st)
   );

   initial clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd);
      return {op, rs, rt, rd, 11'b0};
   endfunction

   function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic nops(input int n);
      for (int i = 0; i < n; i++) prog.push_back(32'd0);
   endtask

   task automatic expw(input logic [4:0] r, input logic [31:0] d);
      exp_q.push_back({r, d});
   endtask

   // Hold reset, clear memory to NOPs and load the pending program.
   task automatic boot();
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 1024; i++) dut.Memory[i] = 32'd0;
      for (int i = 0; i < prog.size(); i++) dut.Memory[i] = prog[i];
      prog.delete();
      exp_q.delete();
   endtask

   task automatic release_rst();
      @(negedge clk1);
      rst_n = 1'b1;
   endtask

   task automatic run_to_halt(input string tag);
      cyc = 0;
      while (dut.HALTED !== 1'b1 && cyc < 100) begin
         @(posedge clk1);
         #1;
         cyc++;
      end
      chk({tag, "_halted"}, 32'(dut.HALTED), 32'd1);
      repeat (3) @(posedge clk1);
      #1;
      chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
   endtask

   // Scoreboard: every WB register write must match the next expected entry.
   always @(negedge clk1) begin
      if (rst_n === 1'b1 && st.wb_we === 1'b1) begin
         ntests++;
         assert (exp_q.size() > 0) else begin
            nfail++;
            $error("FAIL wb_unexpected: observed R%0d=%0h expected no write", st.wb_dst, st.wb_data);
         end
         if (exp_q.size() > 0) begin
            logic [36:0] e;
            e = exp_q.pop_front();
            chk("wb_dst", 32'(st.wb_dst), 32'(e[36:32]));
            chk("wb_data", st.wb_data, e[31:0]);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      #1;
      chk("rst_pc", dut.PC, 32'd0);
      chk("rst_halted", 32'(dut.HALTED), 32'd0);
      chk("rst_wb_we", 32'(st.wb_we), 32'd0);

      // Arithmetic with safe spacing, then an instruction after HLT.
      prog.push_back(rr(OP_ADD, 5'd2, 5'd3, 5'd1));
      nops(3);
      prog.push_back(rr(OP_SUB, 5'd1, 5'd5, 5'd4));
      nops(3);
      prog.push_back(ri(OP_ADDI, 5'd4, 5'd6, 16'd10));
      prog.push_back({OP_HLT, 26'd0});
      prog.push_back(ri(OP_ADDI, 5'd0, 5'd9, 16'd77));
      boot();
      for (int k = 0; k < 32; k++) dut.Register[k] = 32'(k);
      expw(5'd1, 32'd5);
      expw(5'd4, 32'd0);
      expw(5'd6, 32'd10);
      release_rst();
      cyc = 0;
      while (dut.HALTED !== 1'b1 && cyc < 100) begin
         @(posedge clk1);
         #1;
         cyc++;
      end
      chk("arith_halt_cycle", 32'(cyc), 32'd14);
      repeat (5) @(posedge clk1);
      #1;
      chk("arith_pc_frozen", dut.PC, 32'd13);
      chk("arith_drain", 32'(exp_q.size()), 32'd0);
      chk("arith_r1", dut.Register[1], 32'd5);
      chk("arith_r4", dut.Register[4], 32'd0);
      chk("arith_r6", dut.Register[6], 32'd10);
      chk("arith_r9_after_hlt", dut.Register[9], 32'd9);

      // Back-to-back dependency reads the stale value.
      prog.push_back(rr(OP_ADD, 5'd2, 5'd3, 5'd1));
      prog.push_back(rr(OP_SUB, 5'd1, 5'd5, 5'd4));
      prog.push_back({OP_HLT, 26'd0});
      boot();
      for (int k = 0; k < 32; k++) dut.Register[k] = 32'(k);
      expw(5'd1, 32'd5);
      expw(5'd4, 32'hFFFF_FFFC);
      release_rst();
      run_to_halt("hazard");
      chk("hazard_r4", dut.Register[4], 32'hFFFF_FFFC);

      // Load/store.
      prog.push_back(ri(OP_ADDI, 5'd0, 5'd6, 16'd90));
      nops(3);
      prog.push_back(ri(OP_LW, 5'd6, 5'd7, 16'd10));
      nops(3);
      prog.push_back(ri(OP_SW, 5'd6, 5'd7, 16'd14));
      prog.push_back({OP_HLT, 26'd0});
      boot();
      dut.Memory[100] = 32'd555;
      dut.Register[7] = 32'd0;
      expw(5'd6, 32'd90);
      expw(5'd7, 32'd555);
      release_rst();
      run_to_halt("ldst");
      chk("ldst_mem104", dut.Memory[104], 32'd555);
      chk("ldst_r7", dut.Register[7], 32'd555);

      // Branches: BEQZ falls through, taken BNEQZ squashes a HLT and an ADDI.
      prog.push_back(ri(OP_BEQZ, 5'd7, 5'd0, 16'd3));
      prog.push_back(ri(OP_ADDI, 5'd0, 5'd10, 16'd111));
      nops(3);
      prog.push_back(ri(OP_BNEQZ, 5'd7, 5'd0, 16'd2));
      prog.push_back({OP_HLT, 26'd0});
      prog.push_back(ri(OP_ADDI, 5'd0, 5'd12, 16'd222));
      prog.push_back(ri(OP_ADDI, 5'd0, 5'd13, 16'd333));
      prog.push_back({OP_HLT, 26'd0});
      boot();
      dut.Register[7]  = 32'd555;
      dut.Register[10] = 32'd10;
      dut.Register[12] = 32'd12;
      dut.Register[13] = 32'd13;
      expw(5'd10, 32'd111);
      expw(5'd13, 32'd333);
      release_rst();
      run_to_halt("branch");
      chk("branch_r12_squashed", dut.Register[12], 32'd12);
      chk("branch_r13", dut.Register[13], 32'd333);

      // Remaining ALU ops, R0 write ignored, MUL depending on build.
      prog.push_back(rr(OP_MUL, 5'd1, 5'd2, 5'd8));
      prog.push_back(ri(OP_ADDI, 5'd0, 5'd0, 16'd5));
      prog.push_back(rr(OP_SLT, 5'd18, 5'd1, 5'd17));
      prog.push_back(ri(OP_SLTI, 5'd1, 5'd19, 16'hFFFF));
      prog.push_back(rr(OP_AND, 5'd21, 5'd22, 5'd20));
      prog.push_back(rr(OP_OR, 5'd21, 5'd22, 5'd23));
      prog.push_back(ri(OP_SUBI, 5'd1, 5'd24, 16'd7));
      prog.push_back(rr(OP_ADD, 5'd0, 5'd1, 5'd25));
      prog.push_back({OP_HLT, 26'd0});
      boot();
      dut.Register[1]  = 32'd5;
      dut.Register[2]  = 32'd2;
      dut.Register[8]  = 32'd8;
      dut.Register[18] = 32'hFFFF_FFFD;
      dut.Register[19] = 32'd99;
      dut.Register[21] = 32'd12;
      dut.Register[22] = 32'd10;
`ifdef PIPE_MUL_EN
      expw(5'd8, 32'd10);
`endif
      expw(5'd17, 32'd1);
      expw(5'd19, 32'd0);
      expw(5'd20, 32'd8);
      expw(5'd23, 32'd14);
      expw(5'd24, 32'hFFFF_FFFE);
      expw(5'd25, 32'd5);
      release_rst();
      run_to_halt("misc");
`ifdef PIPE_MUL_EN
      chk("misc_mul_r8", dut.Register[8], 32'd10);
`else
      chk("misc_mul_r8", dut.Register[8], 32'd8);
`endif
      chk("misc_r0", dut.Register[0] & 32'd0 | 32'(dut.u_alu.op == 6'h3F), 32'd0);
      chk("misc_r25", dut.Register[25], 32'd5);

      // Async reset while halted clears PC/HALTED immediately, registers survive.
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_pc", dut.PC, 32'd0);
      chk("async_halted", 32'(dut.HALTED), 32'd0);
      chk("async_regs_kept", dut.Register[20], 32'd8);

      // Reset mid-run aborts and restarts from address 0.
      prog.push_back(ri(OP_ADDI, 5'd0, 5'd26, 16'd42));
      nops(19);
      prog.push_back(ri(OP_ADDI, 5'd0, 5'd15, 16'd123));
      prog.push_back({OP_HLT, 26'd0});
      boot();
      dut.Register[26] = 32'd0;
      dut.Register[15] = 32'd0;
      expw(5'd26, 32'd42);
      release_rst();
      repeat (8) @(posedge clk1);
      #1;
      chk("midrst_pc_before", dut.PC, 32'd8);
      chk("midrst_r26_before", dut.Register[26], 32'd42);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_pc", dut.PC, 32'd0);
      chk("midrst_r26_kept", dut.Register[26], 32'd42);
      expw(5'd26, 32'd42);
      expw(5'd15, 32'd123);
      release_rst();
      run_to_halt("midrst");
      chk("midrst_r15", dut.Register[15], 32'd123);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
